// File: rtl/bullet_pkg.sv
//==============================================================================
// Module      : bullet_pkg
// Description : Shared constants, field slices and FSM state type for the
//               bullet line scanner and its interval-match helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bullet_pkg;

    // Default geometry of the attribute table and coordinate space
    localparam int COORD_W = 8;
    localparam int N_SLOTS = 8;

    // Colour codes as stored in the attribute table
    localparam logic [2:0] COLOR_WHITE = 3'b000;
    localparam logic [2:0] COLOR_GREEN = 3'b001;
    localparam logic [2:0] COLOR_BLUE  = 3'b010;

    // Field positions inside the 16-bit position and size words
    localparam int POS_X_LSB  = 8;
    localparam int POS_Y_LSB  = 0;
    localparam int SIZE_W_LSB = 8;
    localparam int SIZE_H_LSB = 0;

    // Scanner state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_READY = 2'd2
    } scan_state_e;

endpackage : bullet_pkg

`default_nettype wire

// File: rtl/bullet_span_match.sv
//==============================================================================
// Module      : bullet_span_match
// Description : Combinational half-open interval test: hit when
//               lo <= q < lo + len, with the end point formed one bit wider
//               so that spans touching the top of the coordinate range never
//               wrap around. A zero length never hits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bullet_span_match
    import bullet_pkg::*;
#(
    parameter int WIDTH = COORD_W
) (
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] len_i,
    input  logic [WIDTH-1:0] q_i,
    output logic             hit_o
);

    // Exclusive end of the span, one bit wider than the operands
    logic [WIDTH:0] w_end;

    assign w_end = {1'b0, lo_i} + {1'b0, len_i};
    assign hit_o = (len_i != '0) && (q_i >= lo_i) && ({1'b0, q_i} < w_end);

endmodule : bullet_span_match

`default_nettype wire

// File: rtl/bullet_line_scanner.sv
//==============================================================================
// Module      : bullet_line_scanner
// Description : During hblank, walks the bullet attribute table two slots per
//               cycle and latches the bullets crossing the next scanline into
//               an active list. During the visible line, reports per pixel
//               (one cycle later) whether a bullet covers it and its colour;
//               the lowest slot index wins on overlap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bullet_line_scanner #(
    parameter int N_SLOTS = bullet_pkg::N_SLOTS,
    parameter int COORD_W = bullet_pkg::COORD_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       line_start,
    input  logic [COORD_W-1:0]         line_y,
    input  logic                       pixel_valid,
    input  logic [COORD_W-1:0]         pixel_x,
    output logic [$clog2(N_SLOTS)-1:0] index1,
    output logic [$clog2(N_SLOTS)-1:0] index2,
    input  logic [15:0]                position1,
    input  logic [15:0]                position2,
    input  logic [15:0]                size1,
    input  logic [15:0]                size2,
    input  logic [2:0]                 color1,
    input  logic [2:0]                 color2,
    input  logic                       isRender1,
    input  logic                       isRender2,
    output logic                       scan_busy,
    output logic                       pixel_hit,
    output logic [2:0]                 pixel_color
);

    localparam int IDX_W   = $clog2(N_SLOTS);
    localparam int N_PAIRS = N_SLOTS / 2;
    localparam int PAIR_W  = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(N_PAIRS - 1);

    bullet_pkg::scan_state_e state_q, state_d;
    logic [PAIR_W-1:0]       k_q, k_d;
    logic [COORD_W-1:0]      line_y_q;

    // Active list: one entry per slot
    logic [N_SLOTS-1:0]      act_valid_q;
    logic [COORD_W-1:0]      act_x_q     [N_SLOTS];
    logic [COORD_W-1:0]      act_w_q     [N_SLOTS];
    logic [2:0]              act_color_q [N_SLOTS];

    logic                    pixel_hit_q, pixel_hit_d;
    logic [2:0]              pixel_color_q, pixel_color_d;

    logic                    w_vspan1, w_vspan2;
    logic                    w_vhit1, w_vhit2;
    logic [N_SLOTS-1:0]      w_hspan;
    logic [N_SLOTS-1:0]      w_slot_hit;

    // The slot pair being read is a direct function of the registered counter,
    // which rests at zero outside SCAN so the ports idle at 0/1.
    assign index1    = IDX_W'({k_q, 1'b0});
    assign index2    = IDX_W'({k_q, 1'b1});
    assign scan_busy = (state_q == bullet_pkg::ST_SCAN);

    assign pixel_hit   = pixel_hit_q;
    assign pixel_color = pixel_color_q;

    // Vertical test for the two slots presented this cycle
    bullet_span_match #(.WIDTH(COORD_W)) u_vmatch1 (
        .lo_i  (position1[bullet_pkg::POS_Y_LSB +: COORD_W]),
        .len_i (size1[bullet_pkg::SIZE_H_LSB +: COORD_W]),
        .q_i   (line_y_q),
        .hit_o (w_vspan1)
    );

    bullet_span_match #(.WIDTH(COORD_W)) u_vmatch2 (
        .lo_i  (position2[bullet_pkg::POS_Y_LSB +: COORD_W]),
        .len_i (size2[bullet_pkg::SIZE_H_LSB +: COORD_W]),
        .q_i   (line_y_q),
        .hit_o (w_vspan2)
    );

    assign w_vhit1 = isRender1 & w_vspan1;
    assign w_vhit2 = isRender2 & w_vspan2;

    // Horizontal test, one per active-list entry
    generate
        for (genvar s = 0; s < N_SLOTS; s++) begin : g_hmatch
            bullet_span_match #(.WIDTH(COORD_W)) u_hmatch (
                .lo_i  (act_x_q[s]),
                .len_i (act_w_q[s]),
                .q_i   (pixel_x),
                .hit_o (w_hspan[s])
            );
            assign w_slot_hit[s] = act_valid_q[s] & w_hspan[s];
        end
    endgenerate

    // State, pair counter and sampled line number
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= bullet_pkg::ST_IDLE;
            k_q      <= '0;
            line_y_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (line_start) begin
                line_y_q <= line_y;
            end
        end
    end

    // Next state: a line_start always (re)starts the scan from pair 0
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        if (line_start) begin
            state_d = bullet_pkg::ST_SCAN;
            k_d     = '0;
        end else begin
            case (state_q)
                bullet_pkg::ST_SCAN: begin
                    if (k_q == LAST_PAIR) begin
                        state_d = bullet_pkg::ST_READY;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Active-list fill: cleared when a scan starts, then written pair by pair
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_valid_q <= '0;
            for (int s = 0; s < N_SLOTS; s++) begin
                act_x_q[s]     <= '0;
                act_w_q[s]     <= '0;
                act_color_q[s] <= '0;
            end
        end else if (line_start) begin
            act_valid_q <= '0;
        end else if (state_q == bullet_pkg::ST_SCAN) begin
            act_valid_q[index1] <= w_vhit1;
            act_x_q[index1]     <= position1[bullet_pkg::POS_X_LSB +: COORD_W];
            act_w_q[index1]     <= size1[bullet_pkg::SIZE_W_LSB +: COORD_W];
            act_color_q[index1] <= color1;
            act_valid_q[index2] <= w_vhit2;
            act_x_q[index2]     <= position2[bullet_pkg::POS_X_LSB +: COORD_W];
            act_w_q[index2]     <= size2[bullet_pkg::SIZE_W_LSB +: COORD_W];
            act_color_q[index2] <= color2;
        end
    end

    // Pixel lookup: lowest matching slot wins; a concurrent line_start forces a miss
    always_comb begin
        pixel_hit_d   = 1'b0;
        pixel_color_d = bullet_pkg::COLOR_WHITE;
        if ((state_q == bullet_pkg::ST_READY) && pixel_valid && !line_start) begin
            for (int s = N_SLOTS - 1; s >= 0; s--) begin
                if (w_slot_hit[s]) begin
                    pixel_hit_d   = 1'b1;
                    pixel_color_d = act_color_q[s];
                end
            end
        end
    end

    // Registered pixel result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_hit_q   <= 1'b0;
            pixel_color_q <= '0;
        end else begin
            pixel_hit_q   <= pixel_hit_d;
            pixel_color_q <= pixel_color_d;
        end
    end

endmodule : bullet_line_scanner

`default_nettype wire

// File: tb/tb_bullet_line_scanner.sv
//==============================================================================
// Module      : tb_bullet_line_scanner
// Description : Directed bench for bullet_line_scanner. Pixel stimulus pushes
//               the expected {hit, colour} into a queue; a monitor pops and
//               compares one cycle later. Scan timing and reset are checked
//               directly.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bullet_line_scanner;
    import bullet_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        line_start;
    logic [7:0]  line_y;
    logic        pixel_valid;
    logic [7:0]  pixel_x;
    logic [2:0]  index1, index2;
    logic [15:0] position1, position2, size1, size2;
    logic [2:0]  color1, color2;
    logic        isRender1, isRender2;
    logic        scan_busy, pixel_hit;
    logic [2:0]  pixel_color;

    // Attribute table model, read asynchronously
    logic [15:0] tbl_pos  [8];
    logic [15:0] tbl_size [8];
    logic [2:0]  tbl_col  [8];
    logic        tbl_ren  [8];

    assign position1 = tbl_pos[index1];
    assign position2 = tbl_pos[index2];
    assign size1     = tbl_size[index1];
    assign size2     = tbl_size[index2];
    assign color1    = tbl_col[index1];
    assign color2    = tbl_col[index2];
    assign isRender1 = tbl_ren[index1];
    assign isRender2 = tbl_ren[index2];

    typedef struct {
        logic       hit;
        logic [2:0] color;
        int         x;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    bullet_line_scanner #(.N_SLOTS(8), .COORD_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .line_y      (line_y),
        .pixel_valid (pixel_valid),
        .pixel_x     (pixel_x),
        .index1      (index1),
        .index2      (index2),
        .position1   (position1),
        .position2   (position2),
        .size1       (size1),
        .size2       (size2),
        .color1      (color1),
        .color2      (color2),
        .isRender1   (isRender1),
        .isRender2   (isRender2),
        .scan_busy   (scan_busy),
        .pixel_hit   (pixel_hit),
        .pixel_color (pixel_color)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: compares the registered result of each presented pixel
    task automatic monitor();
        exp_t e;
        forever begin
            @(posedge clk);
            if (pixel_valid && !reset) begin
                #1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL pixel_unexpected: x=%0d got hit %0b colour %0d expected no pending entry",
                             pixel_x, pixel_hit, pixel_color);
                end else begin
                    e = sb.pop_front();
                    n_vec++;
                    if (pixel_hit !== e.hit || pixel_color !== e.color) begin
                        n_miss++;
                        $display("FAIL pixel x=%0d: got hit %0b colour %0d expected hit %0b colour %0d",
                                 e.x, pixel_hit, pixel_color, e.hit, e.color);
                    end
                end
            end
        end
    endtask

    task automatic clear_table();
        for (int s = 0; s < 8; s++) begin
            tbl_pos[s]  = 16'h0;
            tbl_size[s] = 16'h0;
            tbl_col[s]  = 3'b000;
            tbl_ren[s]  = 1'b0;
        end
    endtask

    task automatic set_slot(input int s, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] w, input logic [7:0] h,
                            input logic [2:0] c, input logic ren);
        tbl_pos[s]  = {x, y};
        tbl_size[s] = {w, h};
        tbl_col[s]  = c;
        tbl_ren[s]  = ren;
    endtask

    // Present one pixel and queue its expected result
    task automatic pix(input int x, input logic hit, input logic [2:0] col);
        exp_t e;
        pixel_valid = 1'b1;
        pixel_x     = x[7:0];
        e.hit = hit; e.color = col; e.x = x;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic sweep(input int x0, input int x1, input int h0, input int h1, input logic [2:0] col);
        for (int x = x0; x <= x1; x++) begin
            if (x >= h0 && x <= h1) pix(x, 1'b1, col);
            else                    pix(x, 1'b0, 3'b000);
        end
        pixel_valid = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] y);
        line_start = 1'b1;
        line_y     = y;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    // Four SCAN cycles with the expected index pairs, pixels forced to miss, then READY
    task automatic scan_watch();
        for (int k = 0; k < 4; k++) begin
            check("scan_busy", 8'(scan_busy), 8'd1);
            check("index1", 8'(index1), 8'(2 * k));
            check("index2", 8'(index2), 8'(2 * k + 1));
            pix(4 + 40 * k, 1'b0, 3'b000);
        end
        pixel_valid = 1'b0;
        check("ready_busy", 8'(scan_busy), 8'd0);
        check("ready_index1", 8'(index1), 8'd0);
    endtask

    task automatic start_line(input logic [7:0] y);
        pulse(y);
        scan_watch();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none

        reset       = 1'b1;
        line_start  = 1'b0;
        line_y      = 8'd0;
        pixel_valid = 1'b0;
        pixel_x     = 8'd0;
        clear_table();
        repeat (3) @(negedge clk);
        check("rst_index1", 8'(index1), 8'd0);
        check("rst_index2", 8'(index2), 8'd1);
        check("rst_busy", 8'(scan_busy), 8'd0);
        check("rst_hit", 8'(pixel_hit), 8'd0);
        check("rst_color", 8'(pixel_color), 8'd0);
        reset = 1'b0;
        @(negedge clk);

        // Pixels in IDLE never hit
        set_slot(3, 8'd4, 8'd4, 8'd80, 8'd80, COLOR_GREEN, 1'b1);
        pix(10, 1'b0, 3'b000);
        pix(20, 1'b0, 3'b000);
        pixel_valid = 1'b0;
        check("idle_busy", 8'(scan_busy), 8'd0);

        // Single bullet in slot 3: x 4..83 on line 10
        start_line(8'd10);
        sweep(0, 90, 4, 83, COLOR_GREEN);
        @(negedge clk);
        check("hit_after_pixels_stop", 8'(pixel_hit), 8'd0);

        // Overlap: slot 2 blue x 10..20, slot 5 white x 10..24
        clear_table();
        set_slot(2, 8'd10, 8'd25, 8'd11, 8'd10, COLOR_BLUE, 1'b1);
        set_slot(5, 8'd10, 8'd28, 8'd15, 8'd5, COLOR_WHITE, 1'b1);
        start_line(8'd30);
        for (int x = 5; x <= 28; x++) begin
            if (x >= 10 && x <= 20)      pix(x, 1'b1, COLOR_BLUE);
            else if (x >= 21 && x <= 24) pix(x, 1'b1, COLOR_WHITE);
            else                         pix(x, 1'b0, 3'b000);
        end
        pixel_valid = 1'b0;

        // Coordinate-range boundaries with a pass-through colour code
        clear_table();
        set_slot(0, 8'd250, 8'd250, 8'd10, 8'd10, 3'b101, 1'b1);
        start_line(8'd249);
        sweep(240, 255, 1, 0, 3'b000);
        start_line(8'd255);
        sweep(240, 255, 250, 255, 3'b101);
        start_line(8'd250);
        sweep(245, 255, 250, 255, 3'b101);

        // Zero width, then zero height
        set_slot(0, 8'd250, 8'd250, 8'd0, 8'd10, 3'b101, 1'b1);
        start_line(8'd252);
        sweep(245, 255, 1, 0, 3'b000);
        set_slot(0, 8'd250, 8'd250, 8'd10, 8'd0, 3'b101, 1'b1);
        start_line(8'd250);
        sweep(245, 255, 1, 0, 3'b000);

        // Geometrically matching but not rendered: whole line misses
        set_slot(0, 8'd250, 8'd250, 8'd10, 8'd10, 3'b101, 1'b0);
        start_line(8'd252);
        sweep(0, 255, 1, 0, 3'b000);

        // Restart at the second scan cycle with a new line
        clear_table();
        set_slot(1, 8'd40, 8'd100, 8'd5, 8'd1, COLOR_GREEN, 1'b1);
        set_slot(6, 8'd60, 8'd120, 8'd5, 8'd1, COLOR_BLUE, 1'b1);
        pulse(8'd100);
        @(negedge clk);
        check("restart_index1", 8'(index1), 8'd2);
        pulse(8'd120);
        scan_watch();
        sweep(35, 70, 60, 64, COLOR_BLUE);
        start_line(8'd100);
        sweep(35, 70, 40, 44, COLOR_GREEN);

        // line_start together with a matching pixel: the pixel misses
        line_start  = 1'b1;
        line_y      = 8'd100;
        pix(42, 1'b0, 3'b000);
        line_start  = 1'b0;
        pixel_valid = 1'b0;
        scan_watch();
        pix(42, 1'b1, COLOR_GREEN);
        pixel_valid = 1'b0;

        // Reset clears a live hit immediately
        check("hit_before_reset", 8'(pixel_hit), 8'd1);
        reset = 1'b1;
        #1;
        check("async_reset_hit", 8'(pixel_hit), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset in the middle of a scan
        start_line(8'd100);
        pulse(8'd100);
        repeat (2) @(negedge clk);
        check("midscan_index1", 8'(index1), 8'd4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 8'(scan_busy), 8'd0);
        check("midrst_index1", 8'(index1), 8'd0);
        check("midrst_index2", 8'(index2), 8'd1);
        check("midrst_hit", 8'(pixel_hit), 8'd0);
        check("midrst_color", 8'(pixel_color), 8'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 8'(scan_busy), 8'd0);
        pix(42, 1'b0, 3'b000);
        pixel_valid = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_bullet_line_scanner

`default_nettype wire

// File: doc/bullet_line_scanner.md
# bullet_line_scanner

Downstream consumer of the bullet attribute table. During horizontal blanking it scans all 8 bullet slots through the table's two asynchronous read ports. It latches the bullets that intersect the next scanline into an active list. During the visible line it tells the pixel mixer, per pixel, whether a bullet covers that pixel and in which colour.

## Interface
Parameters:
- `N_SLOTS`, 8: bullet slots scanned; must be even; slots are read two per cycle.
- `COORD_W`, 8: game-coordinate width, shared by x, y, width and height.

Ports. Reset is asynchronous and active-high; one clock.
- `clk`  in  1  system clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `line_start`  in  1  one-cycle pulse in hblank; begins a scan for `line_y`.
- `line_y`  in  COORD_W  y of the line about to be displayed; sampled on `line_start`.
- `pixel_valid`  in  1  `pixel_x` is a visible pixel this cycle.
- `pixel_x`  in  COORD_W  current pixel x.
- `index1`, `index2`  out  3  slot select to the table read ports.
- `position1`, `position2`  in  16  [15:8] = x, [7:0] = y.
- `size1`, `size2`  in  16  [15:8] = width, [7:0] = height.
- `color1`, `color2`  in  3  000 white, 001 green, 010 blue.
- `isRender1`, `isRender2`  in  1  slot is live.
- `scan_busy`  out  1  scan in progress.
- `pixel_hit`  out  1  a bullet covers the pixel presented the previous cycle.
- `pixel_color`  out  3  colour of the winning bullet; 000 when `pixel_hit` = 0.

## Operation
- FSM states: IDLE, SCAN, READY.
  - Reset enters IDLE.
  - `line_start` in any state enters SCAN with pair counter k = 0.
  - SCAN lasts N_SLOTS/2 cycles, then enters READY.
  - READY holds until the next `line_start`.
- In SCAN, `index1` = 2k and `index2` = 2k+1. Read data is combinational from the table and is consumed in the same cycle.
- Per slot s, the vertical test is: `isRender` && h ≠ 0 && `line_y` ≥ y && `line_y` < y + h.
  - The sum is computed at COORD_W+1 bits, so it never wraps. Example: y = 250, h = 10 covers lines 250..255 only.
- The active list holds N_SLOTS entries of {valid, x, w, color}.
  - Every entry is written during SCAN: valid = result of the vertical test; the other fields come from the table.
  - Entering SCAN clears all valid bits on the first SCAN cycle. A scan restarted mid-way therefore never mixes data from two lines.
- Horizontal match is evaluated only in READY with `pixel_valid` = 1: entry valid && `pixel_x` ≥ x && `pixel_x` < x + w, using COORD_W+1-bit arithmetic.
- Priority: the lowest slot index wins when several entries match.
- When not in READY, or `pixel_valid` = 0, the next `pixel_hit` = 0 and `pixel_color` = 000.
- Colour codes 011..111 are passed through unmodified.

## Timing
- Reset values:
  - `index1` = 0, `index2` = 1.
  - `scan_busy` = 0, `pixel_hit` = 0, `pixel_color` = 000.
  - All active-list valid bits = 0; state IDLE.
- Scan timing: `line_start` at cycle t gives `scan_busy` = 1 in cycles t+1 .. t+N_SLOTS/2, and READY from cycle t+N_SLOTS/2+1 (t+5 for the defaults).
- The index outputs are registered and change in step with k. Outside SCAN they hold 0/1.
- Pixel latency: `pixel_x` presented at cycle n produces `pixel_hit`/`pixel_color` registered at n+1. A full pixel rate of one per cycle is sustained.
- Simultaneous `line_start` and `pixel_valid`: `line_start` wins, and the next output is a miss.
- Reset asserted mid-scan: the next cycle is IDLE with all outputs at their reset values.

## Structure
- Shared package `bullet_pkg`:
  - `COORD_W`, `N_SLOTS`.
  - Colour constants `COLOR_WHITE` = 3'b000, `COLOR_GREEN` = 3'b001, `COLOR_BLUE` = 3'b010.
  - Field slice positions for the position and size words.
  - FSM state enum.
- One sub-module, `bullet_span_match`: a combinational half-open interval test (lo, len, q → hit) at COORD_W+1 bits.
  - Instantiated for the vertical test (×2, one per read port).
  - Instantiated for the horizontal test (×N_SLOTS).

## Test plan
- Single bullet, slot 3 = {x 4, y 4, w 80, h 80, green, render}. Scan `line_y` = 10, then sweep x 0..90 → hit for x 4..83 only, colour 001, one cycle after each x.
- Overlap: slot 2 = blue and slot 5 = white, both covering x 10..20 on line 30 → hit with colour 010 (lower slot wins) for x 10..20.
- Boundaries: y 250, h 10, x 250, w 10.
  - `line_y` 249 → no hits.
  - `line_y` 255 → hits for x 250..255.
  - Size 0 in any dimension → never hits.
- `isRender` = 0 on a geometrically matching slot → `pixel_hit` stays 0 across the whole line.
- Restart and reset: `line_start` again at scan cycle 2 with a new `line_y` → READY 5 cycles after the second pulse, holding only the new line's entries. Reset asserted mid-scan → IDLE, all outputs 0.
- Pixels presented during SCAN or IDLE → `pixel_hit` = 0; `index1`/`index2` sequence 0/1, 2/3, 4/5, 6/7 observed during SCAN.
